// File: rtl/sub_bytes_pkg.sv
// Shared types and constants for the sequential AES SubBytes engine.
// Optional inverse S-box support is controlled by SUBBYTES_INV_EN (see sbox_lane).
package sub_bytes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NBYTES = 16;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One byte-wide AES S-box lane: forward table always, inverse table and a 2:1
// select only when SUBBYTES_INV_EN is defined.
module sbox_lane (
  input  logic [7:0] in_byte,
  input  logic       inv,
  output logic [7:0] out_byte
);

  localparam logic [7:0] FWD_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef SUBBYTES_INV_EN
  localparam logic [7:0] INV_TABLE [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign out_byte = inv ? INV_TABLE[in_byte] : FWD_TABLE[in_byte];
`else
  // Forward-only build: the select is kept on the port but has no effect.
  logic unused_inv;
  assign unused_inv = inv;
  assign out_byte   = FWD_TABLE[in_byte];
`endif

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: LANES S-box lanes walk the 16-byte state in 16/LANES
// cycles behind valid/ready handshakes. Inverse tables exist only with SUBBYTES_INV_EN.
module sub_bytes_seq
  import sub_bytes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         ctrl,
  input  logic         inv,
  input  logic [127:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);

  localparam int N     = NBYTES / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NBYTES-1:0][7:0]  data_q, data_d;
  logic                    inv_q, inv_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    accept;
  logic [LANES-1:0][3:0]   lane_idx;
  logic [LANES-1:0][7:0]   lane_in;
  logic [LANES-1:0][7:0]   lane_out;

  // Lane l works on byte cnt*LANES + l, so the word is swept lowest byte first.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = 4'(int'(cnt_q) * LANES + l);
      lane_in[l]  = data_q[lane_idx[l]];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .in_byte  (lane_in[l]),
      .inv      (inv_q),
      .out_byte (lane_out[l])
    );
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out       = data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    inv_d   = inv_q;
    if (accept) begin
      data_d  = in;
      inv_d   = inv;
      cnt_d   = '0;
      state_d = ctrl ? RUN : DONE;
    end else begin
      case (state_q)
        RUN: begin
          for (int l = 0; l < LANES; l++) begin
            data_d[lane_idx[l]] = lane_out[l];
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end
        end
        DONE:    if (out_ready) state_d = IDLE;
        default: ;
      endcase
    end
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Self-checking bench for sub_bytes_seq: S-box derived from GF(2^8) arithmetic,
// transaction-level predictor, per-cycle compare. Honours SUBBYTES_INV_EN.
module tb_sub_bytes_seq;

  localparam int LANES = 4;
  localparam int N     = 16 / LANES;
`ifdef SUBBYTES_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         ctrl = 1'b0;
  logic         inv = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] in_w = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_w;

  int n_checks = 0;
  int n_fail   = 0;

  sub_bytes_seq #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .inv       (inv),
    .in        (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference S-box from field arithmetic ----------------
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] subword(input logic [127:0] w, input bit use_inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = use_inv ? inv_t[w[8*i +: 8]] : fwd_t[w[8*i +: 8]];
    return r;
  endfunction

  // ---------------- transaction-level predictor ----------------
  bit           m_live = 1'b0;
  bit           m_pend = 1'b0;
  bit           m_outv = 1'b0;
  bit           m_acc;
  int           m_left = 0;
  logic [127:0] m_res = '0;
  logic [127:0] m_out = '0;
  logic         exp_rdy;

  assign exp_rdy = !m_pend && (!m_outv || out_ready);

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1; m_pend = 1'b0; m_outv = 1'b0; m_left = 0; m_out = '0;
    end else if (m_live) begin
      m_acc = in_valid && !m_pend && (!m_outv || out_ready);
      if (m_pend) begin
        m_left--;
        if (m_left == 0) begin m_pend = 1'b0; m_outv = 1'b1; m_out = m_res; end
      end else if (m_outv && out_ready) begin
        m_outv = 1'b0;
      end
      if (m_acc) begin
        if (ctrl) begin
          m_pend = 1'b1; m_left = N; m_outv = 1'b0;
          m_res  = subword(in_w, inv && INV_EN);
        end else begin
          m_outv = 1'b1; m_out = in_w;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", 128'(in_ready), 128'(exp_rdy));
      chk("out_valid", 128'(out_valid), 128'(m_outv));
      chk("busy", 128'(busy), 128'(m_pend || m_outv));
      if (m_outv) chk("out", out_w, m_out);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] w, hold;
  int           t;
  int           rc;

  initial begin
    for (int v = 0; v < 256; v++) begin
      fwd_t[v]                   = affine(ginv(8'(v)));
      inv_t[affine(ginv(8'(v)))] = 8'(v);
    end
    chk("model_sbox_00", 128'(fwd_t[8'h00]), 128'h63);
    chk("model_sbox_01", 128'(fwd_t[8'h01]), 128'h7c);
    chk("model_sbox_53", 128'(fwd_t[8'h53]), 128'hed);
    chk("model_inv_63", 128'(inv_t[8'h63]), 128'h00);

    // Reset held for two edges.
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_out_valid", 128'(out_valid), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_in_ready", 128'(in_ready), 128'h1);
    chk("rst_out", out_w, 128'h0);

    // Forward substitution of an all-zero word.
    in_valid = 1'b1; ctrl = 1'b1; inv = 1'b0; in_w = '0;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("fwd_run_in_ready", 128'(in_ready), 128'h0);
      chk("fwd_run_out_valid", 128'(out_valid), 128'h0);
      cyc();
    end
    chk("fwd_done_valid", 128'(out_valid), 128'h1);
    chk("fwd_done_out", out_w, {16{8'h63}});
    cyc();

    // Bypass word A, then word B accepted in the DONE cycle.
    in_valid = 1'b1; ctrl = 1'b0; in_w = {16{8'h53}};
    cyc();
    chk("byp_valid", 128'(out_valid), 128'h1);
    chk("byp_out", out_w, {16{8'h53}});
    chk("b2b_in_ready", 128'(in_ready), 128'h1);
    ctrl = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("b2b_run_valid", 128'(out_valid), 128'h0);
    repeat (N - 1) cyc();
    chk("b2b_not_early", 128'(out_valid), 128'h0);
    cyc();
    chk("b2b_valid", 128'(out_valid), 128'h1);
    chk("b2b_out", out_w, {16{8'hed}});
    cyc();

    // Backpressure: new word offered while the result is held.
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    out_ready = 1'b0; in_valid = 1'b1; ctrl = 1'b1; inv = 1'b0; in_w = w;
    cyc();
    in_w = {$urandom(), $urandom(), $urandom(), $urandom()};
    t = 0;
    while (!out_valid && t < 64) begin cyc(); t++; end
    chk("bp_reach_done", 128'(out_valid), 128'h1);
    chk("bp_out", out_w, subword(w, 1'b0));
    hold = out_w;
    repeat (10) begin
      cyc();
      chk("bp_hold_out", out_w, hold);
      chk("bp_hold_valid", 128'(out_valid), 128'h1);
      chk("bp_in_ready", 128'(in_ready), 128'h0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("bp_release_valid", 128'(out_valid), 128'h0);
    chk("bp_release_busy", 128'(busy), 128'h0);

    // Inverse request.
    in_valid = 1'b1; ctrl = 1'b1; inv = 1'b1; in_w = {16{8'h63}};
    cyc();
    in_valid = 1'b0; inv = 1'b0;
    repeat (N) cyc();
    chk("inv_out", out_w, INV_EN ? 128'h0 : {16{8'hfb}});
    cyc();

    // Reset in the middle of RUN.
    rc = (N - 1 < 7) ? N - 1 : 7;
    in_valid = 1'b1; ctrl = 1'b1; in_w = {$urandom(), $urandom(), $urandom(), $urandom()};
    cyc();
    in_valid = 1'b0;
    repeat (rc) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_out", out_w, 128'h0);
    chk("mrst_busy", 128'(busy), 128'h0);
    chk("mrst_valid", 128'(out_valid), 128'h0);
    chk("mrst_in_ready", 128'(in_ready), 128'h1);
    repeat (2 * N + 2) begin
      cyc();
      chk("mrst_no_valid", 128'(out_valid), 128'h0);
    end
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_valid = 1'b1; ctrl = 1'b1; in_w = w;
    cyc();
    in_valid = 1'b0;
    repeat (N) cyc();
    chk("mrst_next_valid", 128'(out_valid), 128'h1);
    chk("mrst_next_out", out_w, subword(w, 1'b0));
    cyc();

    // Random traffic with occasional reset.
    repeat (600) begin
      in_valid  = 1'($urandom_range(0, 1));
      ctrl      = ($urandom_range(0, 3) != 0);
      inv       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      in_w      = {$urandom(), $urandom(), $urandom(), $urandom()};
      cyc();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (N + 3) cyc();
    chk("drain_idle", 128'(busy), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
